// File: rtl/mac_cluster_sequencer_pkg.sv
// Shared constants for the mac_cluster sequencer: mode encodings, cfg bit
// positions and the sequencer state type.
package mac_const;

    localparam logic [1:0] MAC_SINGLE = 2'd0;
    localparam logic [1:0] MAC_DUAL   = 2'd1;
    localparam logic [1:0] MAC_QUAD   = 2'd2;

    localparam int unsigned CFG_ACC    = 2;
    localparam int unsigned CFG_SIGNED = 3;

    typedef enum logic [2:0] {
        IDLE,
        CSET,
        STREAM,
        DRAIN,
        RESP
    } seq_state_e;

endpackage

// File: rtl/mac_cluster_sequencer.sv
// Job sequencer for mac_cluster: loads config via cset, streams operand beats,
// waits out the cluster latency and returns the accumulators on a result port.
module mac_cluster_sequencer
    import mac_const::*;
#(
    parameter int unsigned MAC_CONF_WIDTH = 4,
    parameter int unsigned MAC_MIN_WIDTH  = 8,
    parameter int unsigned MAC_ACC_WIDTH  = 32,
    parameter int unsigned LEN_WIDTH      = 16,
    parameter int unsigned MAC_LAT        = 3
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      cmd_valid,
    output logic                                      cmd_ready,
    input  logic [MAC_CONF_WIDTH-1:0]                 cmd_cfg,
    input  logic [4*MAC_ACC_WIDTH-1:0]                cmd_init,
    input  logic [LEN_WIDTH-1:0]                      cmd_len,
    input  logic                                      op_valid,
    output logic                                      op_ready,
    input  logic [4*MAC_MIN_WIDTH-1:0]                op_a,
    input  logic [4*MAC_MIN_WIDTH-1:0]                op_b,
    output logic                                      mac_cset,
    output logic                                      mac_en,
    output logic [4*MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] mac_cfg,
    output logic [4*MAC_MIN_WIDTH-1:0]                mac_a,
    output logic [4*MAC_MIN_WIDTH-1:0]                mac_b,
    input  logic [4*MAC_ACC_WIDTH-1:0]                mac_out,
    output logic                                      res_valid,
    input  logic                                      res_ready,
    output logic [4*MAC_ACC_WIDTH-1:0]                res_data
);

    localparam int unsigned CntW = ($clog2(MAC_LAT + 1) > 0) ? $clog2(MAC_LAT + 1) : 1;
    localparam int unsigned OpW  = 4 * MAC_MIN_WIDTH;
    localparam int unsigned AccW = 4 * MAC_ACC_WIDTH;
    localparam int unsigned CfgW = 4 * MAC_ACC_WIDTH + MAC_CONF_WIDTH;

    seq_state_e           state_q, state_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 op_ready_q, op_ready_d;
    logic                 mac_cset_q, mac_cset_d;
    logic                 mac_en_q, mac_en_d;
    logic [CfgW-1:0]      mac_cfg_q, mac_cfg_d;
    logic [OpW-1:0]       mac_a_q, mac_a_d;
    logic [OpW-1:0]       mac_b_q, mac_b_d;
    logic                 res_valid_q, res_valid_d;
    logic [AccW-1:0]      res_data_q, res_data_d;
    logic                 op_fire;

    assign op_fire = op_valid && op_ready_q && (state_q == STREAM);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        op_ready_d  = op_ready_q;
        mac_cset_d  = 1'b0;
        mac_en_d    = 1'b1;
        mac_cfg_d   = mac_cfg_q;
        // Operand lanes idle at zero unless a beat is accepted this cycle.
        mac_a_d     = '0;
        mac_b_d     = '0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    mac_cfg_d   = {cmd_init, cmd_cfg};
                    remaining_d = cmd_len;
                    mac_cset_d  = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = CSET;
                end
            end
            CSET: begin
                if (remaining_q != '0) begin
                    op_ready_d = 1'b1;
                    state_d    = STREAM;
                end else begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            STREAM: begin
                if (op_fire) begin
                    mac_a_d     = op_a;
                    mac_b_d     = op_b;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        op_ready_d = 1'b0;
                        cnt_d      = CntW'(MAC_LAT);
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    res_data_d  = mac_out;
                    res_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                op_ready_d  = 1'b0;
                cmd_ready_d = 1'b1;
                res_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            op_ready_q  <= 1'b0;
            mac_cset_q  <= 1'b0;
            mac_en_q    <= 1'b1;
            mac_cfg_q   <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            op_ready_q  <= op_ready_d;
            mac_cset_q  <= mac_cset_d;
            mac_en_q    <= mac_en_d;
            mac_cfg_q   <= mac_cfg_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign op_ready  = op_ready_q;
    assign mac_cset  = mac_cset_q;
    assign mac_en    = mac_en_q;
    assign mac_cfg   = mac_cfg_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_mac_cluster_sequencer.sv
// Bench for mac_cluster_sequencer driving a behavioural mac_cluster model with
// a three-cycle operand-to-output latency; results are checked from a scoreboard.
module tb_mac_cluster_sequencer;
    import mac_const::*;

    localparam int unsigned CW  = 4;
    localparam int unsigned MW  = 8;
    localparam int unsigned AW  = 32;
    localparam int unsigned LW  = 16;
    localparam int unsigned LAT = 3;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CW-1:0]    cmd_cfg;
    logic [4*AW-1:0]  cmd_init;
    logic [LW-1:0]    cmd_len;
    logic             op_valid;
    logic             op_ready;
    logic [4*MW-1:0]  op_a;
    logic [4*MW-1:0]  op_b;
    logic             mac_cset;
    logic             mac_en;
    logic [4*AW+CW-1:0] mac_cfg;
    logic [4*MW-1:0]  mac_a;
    logic [4*MW-1:0]  mac_b;
    logic [4*AW-1:0]  mac_out;
    logic             res_valid;
    logic             res_ready;
    logic [4*AW-1:0]  res_data;

    mac_cluster_sequencer #(
        .MAC_CONF_WIDTH(CW),
        .MAC_MIN_WIDTH (MW),
        .MAC_ACC_WIDTH (AW),
        .LEN_WIDTH     (LW),
        .MAC_LAT       (LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_cfg  (cmd_cfg),
        .cmd_init (cmd_init),
        .cmd_len  (cmd_len),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .mac_cset (mac_cset),
        .mac_en   (mac_en),
        .mac_cfg  (mac_cfg),
        .mac_a    (mac_a),
        .mac_b    (mac_b),
        .mac_out  (mac_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cluster model: two operand stages ahead of the accumulator register.
    logic [31:0]  s1_a, s1_b, s2_a, s2_b;
    logic [3:0]   cl_cfg;
    logic [127:0] cl_acc;
    assign mac_out = cl_acc;

    function automatic logic [127:0] mac_step(input logic [3:0] cfg, input logic [127:0] acc,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [127:0] r, ea, eb, p;
        r = '0;
        case (cfg[1:0])
            MAC_SINGLE: begin
                for (int i = 0; i < 4; i++) begin
                    ea = cfg[CFG_SIGNED] ? 128'($signed(a[8*i+:8])) : 128'(a[8*i+:8]);
                    eb = cfg[CFG_SIGNED] ? 128'($signed(b[8*i+:8])) : 128'(b[8*i+:8]);
                    p  = ea * eb;
                    r[32*i+:32] = (cfg[CFG_ACC] ? acc[32*i+:32] : 32'd0) + p[31:0];
                end
            end
            MAC_DUAL: begin
                for (int j = 0; j < 2; j++) begin
                    ea = cfg[CFG_SIGNED] ? 128'($signed(a[16*j+:16])) : 128'(a[16*j+:16]);
                    eb = cfg[CFG_SIGNED] ? 128'($signed(b[16*j+:16])) : 128'(b[16*j+:16]);
                    p  = ea * eb;
                    r[64*j+:64] = (cfg[CFG_ACC] ? acc[64*j+:64] : 64'd0) + p[63:0];
                end
            end
            default: begin
                ea = cfg[CFG_SIGNED] ? 128'($signed(a)) : 128'(a);
                eb = cfg[CFG_SIGNED] ? 128'($signed(b)) : 128'(b);
                p  = ea * eb;
                r  = (cfg[CFG_ACC] ? acc : 128'd0) + p;
            end
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            s1_a   <= '0;
            s1_b   <= '0;
            s2_a   <= '0;
            s2_b   <= '0;
            cl_cfg <= '0;
            cl_acc <= '0;
        end else if (mac_en) begin
            s1_a <= mac_a;
            s1_b <= mac_b;
            s2_a <= s1_a;
            s2_b <= s1_b;
            if (mac_cset) begin
                cl_acc <= mac_cfg[4*AW+CW-1:CW];
                cl_cfg <= mac_cfg[CW-1:0];
            end else begin
                cl_acc <= mac_step(cl_cfg, cl_acc, s2_a, s2_b);
            end
        end
    end

    int errors = 0;
    int checks = 0;
    logic [127:0] exp_q[$];

    task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input string tag, input logic [3:0] cfg, input logic [127:0] init,
                            input logic [15:0] len, input logic [127:0] expv);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_cmd_ready"}, 132'(cmd_ready), 132'(1));
        cmd_cfg   = cfg;
        cmd_init  = init;
        cmd_len   = len;
        cmd_valid = 1'b1;
        exp_q.push_back(expv);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input bit gap);
        logic rdy;
        bit   ok = 1'b0;
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            rdy = op_ready;
            tick();
            if (rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        op_valid = 1'b0;
        chk({tag, "_beat_accept"}, 132'(ok), 132'(1));
        if (gap) tick();
    endtask

    task automatic wait_res(input string tag, input int want);
        int n = 0;
        while (res_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 132'(n), 132'(want));
    endtask

    task automatic consume(input string tag);
        logic [127:0] e = '0;
        chk({tag, "_sb_nonempty"}, 132'(exp_q.size() > 0), 132'(1));
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk({tag, "_data"}, 132'(res_data), 132'(e));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_idle_cmd_ready"}, 132'(cmd_ready), 132'(1));
        chk({tag, "_valid_low"}, 132'(res_valid), 132'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] init;
        bit           saw_op_ready;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_cfg   = '0;
        cmd_init  = '0;
        cmd_len   = '0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_cmd_ready", 132'(cmd_ready), 132'(1));
        chk("rst_op_ready",  132'(op_ready),  132'(0));
        chk("rst_mac_en",    132'(mac_en),    132'(1));
        chk("rst_mac_cset",  132'(mac_cset),  132'(0));
        chk("rst_mac_cfg",   132'(mac_cfg),   132'(0));
        chk("rst_mac_ab",    132'({mac_a, mac_b}), 132'(0));
        chk("rst_res_valid", 132'(res_valid), 132'(0));
        chk("rst_res_data",  132'(res_data),  132'(0));

        // Unsigned single accumulate on lane 0: 4 + 9 + 16.
        send_cmd("single", 4'b0100, 128'd0, 16'd3, 128'd29);
        chk("single_cset", 132'(mac_cset), 132'(1));
        send_beat("single", 32'd2, 32'd2, 1'b0);
        send_beat("single", 32'd3, 32'd3, 1'b0);
        send_beat("single", 32'd4, 32'd4, 1'b0);
        wait_res("single", LAT + 1);
        consume("single");

        // Zero-length job returns the initial accumulators untouched.
        init = {32'hDEADBEEF, 32'd0, 32'd0, 32'h12345678};
        send_cmd("len0", 4'b0100, init, 16'd0, init);
        saw_op_ready = 1'b0;
        for (int n = 0; n < 50 && res_valid !== 1'b1; n++) begin
            if (op_ready === 1'b1) saw_op_ready = 1'b1;
            if (n == 2) break;
            tick();
        end
        chk("len0_latency", 132'(res_valid), 132'(1));
        chk("len0_no_op_ready", 132'(saw_op_ready || op_ready === 1'b1), 132'(0));
        consume("len0");

        // Signed dual, non-accumulate, bubbles between beats; only the last beat counts.
        send_cmd("dual", 4'b1001, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 16'd4,
                 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFE);
        send_beat("dual", 32'h0000_0505, 32'h0000_0707, 1'b1);
        send_beat("dual", 32'h0102_7F01, 32'h0304_0203, 1'b1);
        send_beat("dual", 32'h0000_1234, 32'h0000_0010, 1'b1);
        send_beat("dual", 32'h0000_FFFF, 32'h0000_0002, 1'b0);
        wait_res("dual", LAT + 1);
        consume("dual");

        // Signed quad accumulate of (-1)*(-1) twice, then result backpressure.
        send_cmd("quad", 4'b1110, 128'd0, 16'd2, 128'd2);
        send_beat("quad", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        send_beat("quad", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_res("quad", LAT + 1);
        chk("quad_cfg_held", 132'(mac_cfg), {128'd0, 4'b1110});
        cmd_cfg   = 4'b0101;
        cmd_init  = {4{32'hA5A5_A5A5}};
        cmd_len   = 16'd7;
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_res_data",  132'(res_data),  132'(exp_q[0]));
            chk("bp_res_valid", 132'(res_valid), 132'(1));
            chk("bp_cmd_ready", 132'(cmd_ready), 132'(0));
            chk("bp_mac_cfg",   132'(mac_cfg),   {128'd0, 4'b1110});
            tick();
        end
        cmd_valid = 1'b0;
        consume("quad");
        chk("quad_idle_cfg_kept", 132'(mac_cfg), {128'd0, 4'b1110});
        chk("quad_idle_no_cset",  132'(mac_cset), 132'(0));

        // Reset in the middle of a stream aborts without a result.
        send_cmd("abort", 4'b0100, 128'd0, 16'd5, 128'd0);
        send_beat("abort", 32'h0909_0909, 32'h0909_0909, 1'b0);
        send_beat("abort", 32'h0808_0808, 32'h0808_0808, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(exp_q.pop_back());
        chk("abort_cmd_ready", 132'(cmd_ready), 132'(1));
        chk("abort_op_ready",  132'(op_ready),  132'(0));
        chk("abort_mac_ab",    132'({mac_a, mac_b}), 132'(0));
        chk("abort_res_valid", 132'(res_valid), 132'(0));
        chk("abort_mac_cset",  132'(mac_cset),  132'(0));
        for (int i = 0; i < 6; i++) tick();
        chk("abort_no_result", 132'(res_valid), 132'(0));

        // Follow-up job after the abort: per-lane init plus two beats.
        send_cmd("post", 4'b0100, {32'd4, 32'd3, 32'd2, 32'd1}, 16'd2,
                 {32'd15, 32'd24, 32'd33, 32'd42});
        send_beat("post", {8'd1, 8'd2, 8'd3, 8'd4}, {4{8'd10}}, 1'b0);
        send_beat("post", {4{8'd1}}, {4{8'd1}}, 1'b0);
        wait_res("post", LAT + 1);
        consume("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
